// File: rtl/stack_pkg.sv
// Shared encodings and default constants for the stack sequencer.
// Optional bounds checking in the top is enabled by STACK_BOUNDS_CHECK_EN.
package stack_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC1 = 2'd1,
        S_ACC2 = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_PUSH    = 2'd0,
        OP_POP     = 2'd1,
        OP_PUSH_PC = 2'd2,
        OP_POP_PC  = 2'd3
    } op_t;

    localparam logic [15:0] SP_INIT_DEFAULT     = 16'h07FF;
    localparam logic [15:0] STACK_LIMIT_DEFAULT = 16'h0400;

    // Number of stack words an operation moves.
    function automatic logic [15:0] op_words(input op_t op);
        return (op == OP_PUSH_PC || op == OP_POP_PC) ? 16'd2 : 16'd1;
    endfunction

endpackage

// File: rtl/sp_register.sv
// 16-bit stack pointer with async reset to SP_INIT; wraps modulo 2^16.
// Only one adjust input is expected per cycle; the larger step wins otherwise.
module sp_register
    import stack_pkg::*;
#(
    parameter logic [15:0] SP_INIT = SP_INIT_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_inc1,
    input  logic        i_inc2,
    input  logic        i_dec1,
    input  logic        i_dec2,
    output logic [15:0] o_sp
);

    logic [15:0] r_sp;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sp <= SP_INIT;
        end else if (i_inc2) begin
            r_sp <= r_sp + 16'd2;
        end else if (i_dec2) begin
            r_sp <= r_sp - 16'd2;
        end else if (i_inc1) begin
            r_sp <= r_sp + 16'd1;
        end else if (i_dec1) begin
            r_sp <= r_sp - 16'd1;
        end
    end

    assign o_sp = r_sp;

endmodule

// File: rtl/stack_sequencer.sv
// Push/pop sequencer for a downward-growing stack in single-port data memory.
// Define STACK_BOUNDS_CHECK_EN to reject overflowing/underflowing ops and raise o_fault.
module stack_sequencer
    import stack_pkg::*;
#(
    parameter logic [15:0] SP_INIT     = SP_INIT_DEFAULT,
    parameter logic [15:0] STACK_LIMIT = STACK_LIMIT_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    input  logic        i_push,
    input  logic        i_pop,
    input  logic        i_push_pc,
    input  logic        i_pop_pc,
    input  logic [15:0] i_push_data,
    input  logic [31:0] i_pc,
    input  logic [15:0] i_mem_rdata,
    output logic        o_ready,
    output logic        o_stall,
    output logic [15:0] o_mem_addr,
    output logic [15:0] o_mem_wdata,
    output logic        o_mem_read,
    output logic        o_mem_write,
    output logic [15:0] o_sp,
    output logic [15:0] o_pop_data,
    output logic        o_pop_valid,
    output logic [31:0] o_pc,
    output logic        o_pc_valid,
    output logic        o_fault,
    output logic [1:0]  o_dbg_state
);

    // Handshake: a request is taken on a rising edge where i_req_valid=1,
    // o_ready=1 and at least one op bit is set; otherwise it is not consumed.

    state_t      r_state, w_next_state;
    op_t         r_op, w_req_op;
    logic        r_reject, w_reject;
    logic [15:0] r_data;
    logic [31:0] r_pc;
    logic [15:0] r_pc_lo;
    logic [15:0] r_pop_data;
    logic [31:0] r_pc_out;
    logic        r_pop_valid;
    logic        r_pc_valid;
    logic        w_any_op;
    logic        w_accept;
    logic        w_inc1, w_inc2, w_dec1, w_dec2;
    logic [15:0] w_sp;

    assign w_any_op = i_push | i_pop | i_push_pc | i_pop_pc;
    assign w_accept = (r_state == S_IDLE) && i_req_valid && w_any_op;

    always_comb begin
        w_req_op = OP_PUSH;
        if (i_pop_pc) begin
            w_req_op = OP_POP_PC;
        end else if (i_push_pc) begin
            w_req_op = OP_PUSH_PC;
        end else if (i_pop) begin
            w_req_op = OP_POP;
        end
    end

`ifdef STACK_BOUNDS_CHECK_EN
    logic [15:0] w_room;
    logic [15:0] w_depth;
    logic        r_fault;

    assign w_room  = w_sp - STACK_LIMIT + 16'd1;
    assign w_depth = SP_INIT - w_sp;
    assign w_reject = (w_req_op == OP_PUSH || w_req_op == OP_PUSH_PC)
                    ? (w_room  < op_words(w_req_op))
                    : (w_depth < op_words(w_req_op));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_fault <= 1'b0;
        end else if (w_accept && w_reject) begin
            r_fault <= 1'b1;
        end
    end

    assign o_fault = r_fault;
`else
    logic w_unused_bounds;

    assign w_unused_bounds = ^STACK_LIMIT;
    assign w_reject = 1'b0;
    assign o_fault  = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next_state = S_ACC1;
            S_ACC1: w_next_state = (!r_reject && (r_op == OP_PUSH_PC || r_op == OP_POP_PC))
                                   ? S_ACC2 : S_IDLE;
            S_ACC2: w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_op     <= OP_PUSH;
            r_reject <= 1'b0;
            r_data   <= 16'h0000;
            r_pc     <= 32'h0000_0000;
        end else if (w_accept) begin
            r_op     <= w_req_op;
            r_reject <= w_reject;
            r_data   <= i_push_data;
            r_pc     <= i_pc;
        end
    end

    // Memory controls depend only on state and the latched op.
    always_comb begin
        o_mem_read  = 1'b0;
        o_mem_write = 1'b0;
        o_mem_addr  = w_sp;
        o_mem_wdata = 16'h0000;
        w_inc1 = 1'b0;
        w_inc2 = 1'b0;
        w_dec1 = 1'b0;
        w_dec2 = 1'b0;
        if (r_state == S_ACC1 && !r_reject) begin
            case (r_op)
                OP_PUSH: begin
                    o_mem_write = 1'b1;
                    o_mem_wdata = r_data;
                    w_dec1      = 1'b1;
                end
                OP_POP: begin
                    o_mem_read = 1'b1;
                    o_mem_addr = w_sp + 16'd1;
                    w_inc1     = 1'b1;
                end
                OP_PUSH_PC: begin
                    o_mem_write = 1'b1;
                    o_mem_wdata = r_pc[31:16];
                end
                OP_POP_PC: begin
                    o_mem_read = 1'b1;
                    o_mem_addr = w_sp + 16'd1;
                end
                default: ;
            endcase
        end else if (r_state == S_ACC2) begin
            if (r_op == OP_PUSH_PC) begin
                o_mem_write = 1'b1;
                o_mem_addr  = w_sp - 16'd1;
                o_mem_wdata = r_pc[15:0];
                w_dec2      = 1'b1;
            end else begin
                o_mem_read = 1'b1;
                o_mem_addr = w_sp + 16'd2;
                w_inc2     = 1'b1;
            end
        end
    end

    // The low PC half is parked so o_pc only changes when both halves are in.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pc_lo     <= 16'h0000;
            r_pop_data  <= 16'h0000;
            r_pc_out    <= 32'h0000_0000;
            r_pop_valid <= 1'b0;
            r_pc_valid  <= 1'b0;
        end else begin
            r_pop_valid <= 1'b0;
            r_pc_valid  <= 1'b0;
            if (r_state == S_ACC1 && !r_reject && r_op == OP_POP) begin
                r_pop_data  <= i_mem_rdata;
                r_pop_valid <= 1'b1;
            end
            if (r_state == S_ACC1 && !r_reject && r_op == OP_POP_PC) begin
                r_pc_lo <= i_mem_rdata;
            end
            if (r_state == S_ACC2 && r_op == OP_POP_PC) begin
                r_pc_out   <= {i_mem_rdata, r_pc_lo};
                r_pc_valid <= 1'b1;
            end
        end
    end

    sp_register #(
        .SP_INIT (SP_INIT)
    ) u_sp (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc1  (w_inc1),
        .i_inc2  (w_inc2),
        .i_dec1  (w_dec1),
        .i_dec2  (w_dec2),
        .o_sp    (w_sp)
    );

    assign o_ready     = (r_state == S_IDLE);
    assign o_stall     = ~o_ready;
    assign o_sp        = w_sp;
    assign o_pop_data  = r_pop_data;
    assign o_pop_valid = r_pop_valid;
    assign o_pc        = r_pc_out;
    assign o_pc_valid  = r_pc_valid;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer with a behavioural data memory.
// Expectations for the bounds test follow STACK_BOUNDS_CHECK_EN.
module tb_stack_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, push, pop, push_pc, pop_pc;
    logic [15:0] push_data;
    logic [31:0] pc_in;
    logic [15:0] mem_rdata;
    logic        ready, stall, mem_read, mem_write, pop_valid, pc_valid, fault;
    logic [15:0] mem_addr, mem_wdata, sp, pop_data;
    logic [31:0] pc_out;
    logic [1:0]  dbg_state;

    logic [15:0] mem [0:65535];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    stack_sequencer dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_req_valid (req_valid),
        .i_push      (push),
        .i_pop       (pop),
        .i_push_pc   (push_pc),
        .i_pop_pc    (pop_pc),
        .i_push_data (push_data),
        .i_pc        (pc_in),
        .i_mem_rdata (mem_rdata),
        .o_ready     (ready),
        .o_stall     (stall),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_mem_read  (mem_read),
        .o_mem_write (mem_write),
        .o_sp        (sp),
        .o_pop_data  (pop_data),
        .o_pop_valid (pop_valid),
        .o_pc        (pc_out),
        .o_pc_valid  (pc_valid),
        .o_fault     (fault),
        .o_dbg_state (dbg_state)
    );

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_wdata;
    end

    task automatic idle_inputs();
        req_valid = 1'b0; push = 1'b0; pop = 1'b0; push_pc = 1'b0; pop_pc = 1'b0;
        push_data = 16'h0000; pc_in = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if ({ready, stall, sp, pop_data, pc_out, pop_valid, pc_valid, fault} !==
            {1'b1, 1'b0, 16'h07FF, 16'h0, 32'h0, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset: rdy=%b stl=%b sp=%h pd=%h pc=%h pv=%b cv=%b f=%b exp rdy=1 stl=0 sp=07ff rest 0",
                     ready, stall, sp, pop_data, pc_out, pop_valid, pc_valid, fault);
        end
        total++;
        if ({mem_read, mem_write, mem_addr, mem_wdata} !== {1'b0, 1'b0, 16'h07FF, 16'h0}) begin
            bad++;
            $display("FAIL idle_mem: rd=%b wr=%b addr=%h wd=%h exp 0 0 07ff 0000",
                     mem_read, mem_write, mem_addr, mem_wdata);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_push();
        do_reset();
        req_valid = 1'b1; push = 1'b1; push_data = 16'hABCD;
        @(negedge clk);
        idle_inputs();
        total++;
        if ({stall, ready, mem_write, mem_read, mem_addr, mem_wdata} !==
            {1'b1, 1'b0, 1'b1, 1'b0, 16'h07FF, 16'hABCD}) begin
            bad++;
            $display("FAIL push_acc1: stl=%b rdy=%b wr=%b rd=%b addr=%h wd=%h exp 1 0 1 0 07ff abcd",
                     stall, ready, mem_write, mem_read, mem_addr, mem_wdata);
        end
        @(negedge clk);
        total++;
        if ({sp, ready, mem[16'h07FF]} !== {16'h07FE, 1'b1, 16'hABCD}) begin
            bad++;
            $display("FAIL push_done: sp=%h rdy=%b mem=%h exp 07fe 1 abcd", sp, ready, mem[16'h07FF]);
        end
    endtask

    task automatic test_push_pop_pc();
        do_reset();
        req_valid = 1'b1; push_pc = 1'b1; pc_in = 32'h1234_5678;
        @(negedge clk);
        idle_inputs();
        total++;
        if ({stall, mem_write, mem_addr, mem_wdata} !== {1'b1, 1'b1, 16'h07FF, 16'h1234}) begin
            bad++;
            $display("FAIL pushpc_acc1: stl=%b wr=%b addr=%h wd=%h exp 1 1 07ff 1234",
                     stall, mem_write, mem_addr, mem_wdata);
        end
        @(negedge clk);
        total++;
        if ({stall, mem_write, mem_addr, mem_wdata} !== {1'b1, 1'b1, 16'h07FE, 16'h5678}) begin
            bad++;
            $display("FAIL pushpc_acc2: stl=%b wr=%b addr=%h wd=%h exp 1 1 07fe 5678",
                     stall, mem_write, mem_addr, mem_wdata);
        end
        @(negedge clk);
        total++;
        if ({ready, sp, mem[16'h07FF], mem[16'h07FE]} !== {1'b1, 16'h07FD, 16'h1234, 16'h5678}) begin
            bad++;
            $display("FAIL pushpc_done: rdy=%b sp=%h m7ff=%h m7fe=%h exp 1 07fd 1234 5678",
                     ready, sp, mem[16'h07FF], mem[16'h07FE]);
        end
        req_valid = 1'b1; pop_pc = 1'b1;
        @(negedge clk);
        idle_inputs();
        total++;
        if ({stall, mem_read, mem_write, mem_addr} !== {1'b1, 1'b1, 1'b0, 16'h07FE}) begin
            bad++;
            $display("FAIL poppc_acc1: stl=%b rd=%b wr=%b addr=%h exp 1 1 0 07fe",
                     stall, mem_read, mem_write, mem_addr);
        end
        @(negedge clk);
        total++;
        if ({stall, mem_read, mem_addr, pc_valid} !== {1'b1, 1'b1, 16'h07FF, 1'b0}) begin
            bad++;
            $display("FAIL poppc_acc2: stl=%b rd=%b addr=%h cv=%b exp 1 1 07ff 0",
                     stall, mem_read, mem_addr, pc_valid);
        end
        @(negedge clk);
        total++;
        if ({ready, pc_valid, pc_out, sp} !== {1'b1, 1'b1, 32'h1234_5678, 16'h07FF}) begin
            bad++;
            $display("FAIL poppc_done: rdy=%b cv=%b pc=%h sp=%h exp 1 1 12345678 07ff",
                     ready, pc_valid, pc_out, sp);
        end
        @(negedge clk);
        total++;
        if ({pc_valid, pc_out} !== {1'b0, 32'h1234_5678}) begin
            bad++;
            $display("FAIL poppc_hold: cv=%b pc=%h exp 0 12345678", pc_valid, pc_out);
        end
    endtask

    task automatic test_priority_busy();
        do_reset();
        req_valid = 1'b1; push_pc = 1'b1; pc_in = 32'hCAFE_F00D;
        @(negedge clk);
        idle_inputs();
        repeat (2) @(negedge clk);
        req_valid = 1'b1; push = 1'b1; pop_pc = 1'b1; push_data = 16'h1111;
        @(negedge clk);
        total++;
        if ({mem_read, mem_write, mem_addr} !== {1'b1, 1'b0, 16'h07FE}) begin
            bad++;
            $display("FAIL prio_acc1: rd=%b wr=%b addr=%h exp 1 0 07fe", mem_read, mem_write, mem_addr);
        end
        pop_pc = 1'b0; push_data = 16'h2222;
        @(negedge clk);
        total++;
        if ({mem_write, stall} !== {1'b0, 1'b1}) begin
            bad++;
            $display("FAIL busy_ignored: wr=%b stl=%b exp 0 1", mem_write, stall);
        end
        idle_inputs();
        @(negedge clk);
        total++;
        if ({ready, pc_valid, pc_out, sp, mem[16'h07FF]} !==
            {1'b1, 1'b1, 32'hCAFE_F00D, 16'h07FF, 16'hCAFE}) begin
            bad++;
            $display("FAIL prio_done: rdy=%b cv=%b pc=%h sp=%h m7ff=%h exp 1 1 cafef00d 07ff cafe",
                     ready, pc_valid, pc_out, sp, mem[16'h07FF]);
        end
        @(negedge clk);
        total++;
        if ({ready, sp} !== {1'b1, 16'h07FF}) begin
            bad++;
            $display("FAIL busy_not_latched: rdy=%b sp=%h exp 1 07ff", ready, sp);
        end
    endtask

    task automatic test_pop_and_noop();
        req_valid = 1'b1;
        @(negedge clk);
        total++;
        if ({ready, mem_read, mem_write} !== {1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL noop_req: rdy=%b rd=%b wr=%b exp 1 0 0", ready, mem_read, mem_write);
        end
        push = 1'b1; push_data = 16'hBEEF;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        req_valid = 1'b1; pop = 1'b1;
        @(negedge clk);
        idle_inputs();
        total++;
        if ({mem_read, mem_addr, pop_valid} !== {1'b1, 16'h07FF, 1'b0}) begin
            bad++;
            $display("FAIL pop_acc1: rd=%b addr=%h pv=%b exp 1 07ff 0", mem_read, mem_addr, pop_valid);
        end
        @(negedge clk);
        total++;
        if ({pop_valid, pop_data, sp, ready} !== {1'b1, 16'hBEEF, 16'h07FF, 1'b1}) begin
            bad++;
            $display("FAIL pop_done: pv=%b pd=%h sp=%h rdy=%b exp 1 beef 07ff 1",
                     pop_valid, pop_data, sp, ready);
        end
        @(negedge clk);
        total++;
        if ({pop_valid, pop_data} !== {1'b0, 16'hBEEF}) begin
            bad++;
            $display("FAIL pop_hold: pv=%b pd=%h exp 0 beef", pop_valid, pop_data);
        end
    endtask

    task automatic test_reset_midop();
        do_reset();
        mem[16'h07FF] = 16'h0000;
        mem[16'h07FE] = 16'h0000;
        req_valid = 1'b1; push_pc = 1'b1; pc_in = 32'hAAAA_5555;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        total++;
        if (dbg_state !== 2'd2) begin
            bad++;
            $display("FAIL reach_acc2: state=%0d exp 2", dbg_state);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({ready, sp, mem_write} !== {1'b1, 16'h07FF, 1'b0}) begin
            bad++;
            $display("FAIL abort_reset: rdy=%b sp=%h wr=%b exp 1 07ff 0", ready, sp, mem_write);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({mem[16'h07FF], mem[16'h07FE], pc_valid, pc_out, sp} !==
            {16'hAAAA, 16'h0000, 1'b0, 32'h0, 16'h07FF}) begin
            bad++;
            $display("FAIL abort_after: m7ff=%h m7fe=%h cv=%b pc=%h sp=%h exp aaaa 0000 0 00000000 07ff",
                     mem[16'h07FF], mem[16'h07FE], pc_valid, pc_out, sp);
        end
    endtask

    task automatic test_bounds();
        do_reset();
        req_valid = 1'b1; pop = 1'b1;
        @(negedge clk);
        idle_inputs();
`ifdef STACK_BOUNDS_CHECK_EN
        total++;
        if ({stall, mem_read, fault} !== {1'b1, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL bounds_acc1: stl=%b rd=%b f=%b exp 1 0 1", stall, mem_read, fault);
        end
        @(negedge clk);
        total++;
        if ({ready, sp, fault, pop_valid} !== {1'b1, 16'h07FF, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL bounds_done: rdy=%b sp=%h f=%b pv=%b exp 1 07ff 1 0", ready, sp, fault, pop_valid);
        end
`else
        total++;
        if ({stall, mem_read, mem_addr, fault} !== {1'b1, 1'b1, 16'h0800, 1'b0}) begin
            bad++;
            $display("FAIL bounds_acc1: stl=%b rd=%b addr=%h f=%b exp 1 1 0800 0",
                     stall, mem_read, mem_addr, fault);
        end
        @(negedge clk);
        total++;
        if ({ready, sp, fault} !== {1'b1, 16'h0800, 1'b0}) begin
            bad++;
            $display("FAIL bounds_done: rdy=%b sp=%h f=%b exp 1 0800 0", ready, sp, fault);
        end
`endif
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        rst = 1'b0;
        idle_inputs();
        test_reset();
        test_push();
        test_push_pop_pc();
        test_priority_busy();
        test_pop_and_noop();
        test_reset_midop();
        test_bounds();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stack_sequencer.md
STACK_SEQUENCER -- requirements
Module: stack_sequencer

Interface
REQ-001 SHALL have parameter SP_INIT, default 16'h07FF: stack pointer reset value, the top of the stack; stack grows downward.
REQ-002 SHALL have parameter STACK_LIMIT, default 16'h0400: lowest legal stack address.
REQ-003 SHALL have ports (name, direction, width, meaning):
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  reset, asynchronous, active-high.
- i_req_valid  in  1  request strobe; sampled only while o_ready=1.
- i_push  in  1  single-word push.
- i_pop  in  1  single-word pop.
- i_push_pc  in  1  32-bit PC push (CALL/INT).
- i_pop_pc  in  1  32-bit PC pop (RET/RTI).
- i_push_data  in  16  word for i_push.
- i_pc  in  32  PC for i_push_pc.
- i_mem_rdata  in  16  data memory read data; combinational from o_mem_addr.
- o_ready  out  1  sequencer idle; a request can be accepted.
- o_stall  out  1  equals ~o_ready; freezes upstream pipeline registers.
- o_mem_addr  out  16  data memory address.
- o_mem_wdata  out  16  data memory write data.
- o_mem_read  out  1  memory read enable.
- o_mem_write  out  1  memory write enable.
- o_sp  out  16  current stack pointer.
- o_pop_data  out  16  popped word.
- o_pop_valid  out  1  one-cycle pulse; o_pop_data valid.
- o_pc  out  32  popped PC.
- o_pc_valid  out  1  one-cycle pulse; o_pc valid.
- o_fault  out  1  sticky stack overflow/underflow flag.

Function
REQ-004 SHALL implement FSM states IDLE, ACC1, ACC2. o_ready=1 only in IDLE.
REQ-005 In IDLE with i_req_valid=1, SHALL latch the operation and its data, then go to ACC1.
- Priority when more than one op bit is set: pop_pc > push_pc > pop > push.
- i_req_valid=1 with no op bit set is ignored; FSM stays in IDLE.
REQ-006 Single-word push takes one access cycle (ACC1):
- mem[SP] <= data (o_mem_write=1).
- SP <= SP-1.
- Next state IDLE.
REQ-007 Single-word pop takes one access cycle (ACC1):
- o_mem_addr = SP+1, o_mem_read=1.
- o_pop_data <= i_mem_rdata, SP <= SP+1.
- o_pop_valid pulses in the cycle after ACC1.
REQ-008 PC push takes two access cycles:
- ACC1: mem[SP] <= pc[31:16].
- ACC2: mem[SP-1] <= pc[15:0].
- SP <= SP-2 at the end of ACC2.
REQ-009 PC pop takes two access cycles:
- ACC1: read SP+1 into o_pc[15:0].
- ACC2: read SP+2 into o_pc[31:16].
- SP <= SP+2 at the end of ACC2; o_pc_valid pulses in the cycle after ACC2.
REQ-010 Memory controls SHALL be Moore outputs decoded from state and the latched op.
- In IDLE: o_mem_read=0, o_mem_write=0, o_mem_addr=SP, o_mem_wdata=0.
REQ-011 SP arithmetic SHALL be 16-bit unsigned.
REQ-012 A request presented while o_ready=0 SHALL be ignored; the requester must hold it until o_ready=1.
REQ-013 o_pop_data and o_pc SHALL hold their last value until the next pop of the same kind completes.

Reset
REQ-014 On i_reset=1, independent of i_clk, SHALL immediately set:
- state=IDLE, SP=SP_INIT.
- o_pop_data=0, o_pc=0.
- o_pop_valid=0, o_pc_valid=0, o_fault=0.
REQ-015 A reset asserted mid-operation SHALL abort the operation.
- Memory writes already performed remain in memory.
- No valid pulse is generated.

Configuration
REQ-016 Macro STACK_BOUNDS_CHECK_EN, when defined, enables bounds checking at acceptance:
- Push of n words is rejected if (SP - STACK_LIMIT + 1) < n.
- Pop of n words is rejected if (SP_INIT - SP) < n.
- A rejected op sets o_fault=1 (sticky), performs no memory access, leaves SP unchanged, stalls one cycle in ACC1, then returns to IDLE.
REQ-017 When the macro is undefined, no checking is done, SP wraps modulo 2^16, and o_fault is tied 0.

Structure
REQ-018 SHALL place the state encoding, the op encoding (OP_PUSH, OP_POP, OP_PUSH_PC, OP_POP_PC) and the default SP_INIT/STACK_LIMIT constants in shared package stack_pkg.
REQ-019 SHALL contain one sub-module, sp_register: 16-bit SP with async reset to SP_INIT and inc/dec-by-1/2 inputs. The FSM and output decode stay in the top.

Verification
REQ-020 Reset then single push 16'hABCD -> one cycle with write to 07FF, data ABCD, o_stall=1; then o_sp=07FE and o_ready=1.
REQ-021 Push_pc 32'h1234_5678 at SP=07FF -> mem[07FF]=1234, mem[07FE]=5678, two stall cycles, o_sp=07FD.
REQ-022 Pop_pc immediately after REQ-021 -> reads 07FE then 07FF; o_pc=1234_5678 with o_pc_valid pulse; o_sp=07FF.
REQ-023 push and pop_pc requested together in IDLE -> pop_pc executes; a request presented while busy is ignored.
REQ-024 Reset asserted during ACC2 of push_pc -> immediately IDLE, o_sp=07FF, mem[07FF] keeps the high half, no o_pc_valid.
REQ-025 With STACK_BOUNDS_CHECK_EN defined, single pop at SP=SP_INIT -> no o_mem_read, o_fault=1, o_sp unchanged. Without the macro, the same stimulus -> o_sp=0800, o_fault=0.
